// File: rtl/regfile_mp.sv
// regfile_mp: 2^ADDR_W x DATA_W register file with two write ports and two read ports.
// Writes commit on the rising edge. Clear has the highest priority, then port B, then port A.
// Reads are either combinational, with or without same-cycle write forwarding, or registered
// with one cycle of latency. Entry 0 can optionally be hardwired to zero.
module regfile_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int READ_LAT = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Clear,
  input  logic              Write,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              Write2,
  input  logic [ADDR_W-1:0] WriteReg2,
  input  logic [DATA_W-1:0] WriteData2,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic              ReadEn1,
  input  logic              ReadEn2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Current contents and next-edge value seen by each read port.
  logic [DATA_W-1:0] rd_cur1, rd_cur2;
  logic [DATA_W-1:0] rd_nxt1, rd_nxt2;

  // Next array contents: Clear beats both ports; port B is applied last so it wins a tie.
  always_comb begin
    // NOTE: start from a full copy of the current state so every element is assigned on
    // every path; a missing default here would infer latches.
    mem_d = mem_q;
    if (Clear) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
    end else begin
      if (Write)  mem_d[WriteReg]  = WriteData;
      if (Write2) mem_d[WriteReg2] = WriteData2;
    end
    if (ZERO_REG != 0) mem_d[0] = '0;
  end

  // Storage array with asynchronous clear of every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the entries are reset because an immediate asynchronous clear is part of the
      // block's function; that keeps this storage in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only, so every
      // flop samples values from before the edge.
      mem_q <= mem_d;
    end
  end

  // Per-port view of the stored entry and of the value it takes at the next edge.
  always_comb begin
    rd_cur1 = mem_q[ReadReg1];
    rd_cur2 = mem_q[ReadReg2];
    rd_nxt1 = mem_d[ReadReg1];
    rd_nxt2 = mem_d[ReadReg2];
    if (ZERO_REG != 0) begin
      if (ReadReg1 == '0) rd_cur1 = '0;
      if (ReadReg2 == '0) rd_cur2 = '0;
    end
  end

  if (READ_LAT == 0) begin : g_comb_read
    if (BYPASS != 0) begin : g_bypass
      assign ReadData1 = rd_nxt1;
      assign ReadData2 = rd_nxt2;
      logic unused_rd;
      assign unused_rd = ^{ReadEn1, ReadEn2, rd_cur1, rd_cur2};
    end else begin : g_no_bypass
      assign ReadData1 = rd_cur1;
      assign ReadData2 = rd_cur2;
      logic unused_rd;
      assign unused_rd = ^{ReadEn1, ReadEn2, rd_nxt1, rd_nxt2};
    end
  end else begin : g_reg_read
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic              unused_rd;

    // Output registers load the next value of the addressed entry, so a same-cycle write is seen.
    always_comb begin
      rd1_d = ReadEn1 ? rd_nxt1 : rd1_q;
      rd2_d = ReadEn2 ? rd_nxt2 : rd2_q;
    end

    // Read output registers, cleared together with the array.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd1_q <= '0;
        rd2_q <= '0;
      end else begin
        rd1_q <= rd1_d;
        rd2_q <= rd2_d;
      end
    end

    assign ReadData1 = rd1_q;
    assign ReadData2 = rd2_q;
    assign unused_rd = ^{rd_cur1, rd_cur2};
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench driving six regfile_mp instances in parallel from shared inputs.
// Instances: 0 comb+bypass, 1 comb no bypass, 2 registered, 3..5 the same three with ZERO_REG=1.
// Registered-read results are queued when the read is launched and compared after the edge.
module tb_regfile_mp;

  localparam int N_INST = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       Clear;
  logic       Write, Write2;
  logic [1:0] WriteReg, WriteReg2;
  logic [7:0] WriteData, WriteData2;
  logic [1:0] ReadReg1, ReadReg2;
  logic       ReadEn1, ReadEn2;
  logic [7:0] rd1 [N_INST];
  logic [7:0] rd2 [N_INST];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    int         inst;
    int         port;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    regfile_mp #(
      .DATA_W  (8),
      .ADDR_W  (2),
      .READ_LAT((g == 2 || g == 5) ? 1 : 0),
      .BYPASS  ((g == 0 || g == 3) ? 1 : 0),
      .ZERO_REG((g >= 3) ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .Clear     (Clear),
      .Write     (Write),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .Write2    (Write2),
      .WriteReg2 (WriteReg2),
      .WriteData2(WriteData2),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .ReadEn1   (ReadEn1),
      .ReadEn2   (ReadEn2),
      .ReadData1 (rd1[g]),
      .ReadData2 (rd2[g])
    );
  end

  function automatic logic [7:0] get_rd(int inst, int port);
    return (port == 1) ? rd1[inst] : rd2[inst];
  endfunction

  task automatic check(string tag, int inst, int port, logic [7:0] expected);
    logic [7:0] observed;
    observed = get_rd(inst, port);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s inst=%0d port=%0d observed=%h expected=%h", tag, inst, port, observed, expected);
    end
  endtask

  task automatic push(string tag, int inst, int port, logic [7:0] val);
    exp_t e;
    e.tag = tag; e.inst = inst; e.port = port; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, e.inst, e.port, e.val);
    end
  endtask

  // Advance past one rising edge; inputs driven afterwards apply to the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Clear = 1'b0; Write = 1'b0; Write2 = 1'b0;
    ReadEn1 = 1'b0; ReadEn2 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();
    WriteReg = '0; WriteReg2 = '0; WriteData = '0; WriteData2 = '0;
    ReadReg1 = '0; ReadReg2 = '0;

    // Reset state, before any edge.
    #2;
    for (int k = 0; k < N_INST; k++) begin
      check("reset_state", k, 1, 8'h00);
      check("reset_state", k, 2, 8'h00);
    end
    reset = 1'b1;

    // Fill all four entries with 0xA5.
    step();
    Write = 1'b1; WriteReg = 2'd0; WriteData = 8'hA5;
    Write2 = 1'b1; WriteReg2 = 2'd1; WriteData2 = 8'hA5;
    step();
    WriteReg = 2'd2; WriteReg2 = 2'd3;
    step();
    idle();
    ReadEn1 = 1'b1; ReadEn2 = 1'b1; ReadReg1 = 2'd3; ReadReg2 = 2'd0;
    push("fill_reg_rd", 2, 1, 8'hA5);
    push("fill_reg_rd", 2, 2, 8'hA5);
    push("fill_reg_rd_zero", 5, 1, 8'hA5);
    push("fill_reg_rd_zero", 5, 2, 8'h00);
    step();
    drain();
    idle();
    for (int a = 0; a < 4; a++) begin
      ReadReg1 = 2'(a); ReadReg2 = 2'(a);
      #1;
      check("fill_stored", 1, 1, 8'hA5);
      check("fill_stored", 1, 2, 8'hA5);
    end

    // Asynchronous reset between edges: outputs clear with no clock edge.
    step();
    reset = 1'b0;
    #1;
    check("async_reset_regout", 2, 1, 8'h00);
    check("async_reset_regout", 2, 2, 8'h00);
    check("async_reset_regout_zero", 5, 1, 8'h00);
    for (int a = 0; a < 4; a++) begin
      ReadReg1 = 2'(a); ReadReg2 = 2'(a);
      #1;
      check("async_reset_byp", 0, 1, 8'h00);
      check("async_reset_nbp", 1, 2, 8'h00);
    end
    reset = 1'b1;
    step();

    // Dual write to the same address: port B wins.
    Write = 1'b1; WriteReg = 2'd2; WriteData = 8'h11;
    Write2 = 1'b1; WriteReg2 = 2'd2; WriteData2 = 8'h22;
    ReadReg1 = 2'd2; ReadEn1 = 1'b1;
    #1;
    check("conflict_bypass", 0, 1, 8'h22);
    check("conflict_nobypass_old", 1, 1, 8'h00);
    push("conflict_reg", 2, 1, 8'h22);
    step();
    drain();
    idle();
    #1;
    check("conflict_stored", 1, 1, 8'h22);

    // Dual write to different addresses: both commit.
    Write = 1'b1; WriteReg = 2'd1; WriteData = 8'h33;
    Write2 = 1'b1; WriteReg2 = 2'd3; WriteData2 = 8'h44;
    ReadReg1 = 2'd1; ReadReg2 = 2'd3; ReadEn1 = 1'b1; ReadEn2 = 1'b1;
    #1;
    check("split_bypass_a", 0, 1, 8'h33);
    check("split_bypass_b", 0, 2, 8'h44);
    push("split_reg_a", 2, 1, 8'h33);
    push("split_reg_b", 2, 2, 8'h44);
    push("split_reg_zero_a", 5, 1, 8'h33);
    push("split_reg_zero_b", 5, 2, 8'h44);
    step();
    drain();
    idle();
    #1;
    check("split_stored_a", 1, 1, 8'h33);
    check("split_stored_b", 1, 2, 8'h44);

    // Bypass vs no bypass on a port A write.
    Write = 1'b1; WriteReg = 2'd1; WriteData = 8'h5C; ReadReg1 = 2'd1;
    #1;
    check("bypass_fwd", 0, 1, 8'h5C);
    check("nobypass_old", 1, 1, 8'h33);
    step();
    idle();
    #1;
    check("nobypass_new", 1, 1, 8'h5C);

    // Registered read with a same-cycle write to the same entry.
    Write = 1'b1; WriteReg = 2'd3; WriteData = 8'h7E;
    ReadReg1 = 2'd3; ReadEn1 = 1'b1;
    #1;
    check("regrd_before_edge", 2, 1, 8'h33);
    push("regrd_write_first", 2, 1, 8'h7E);
    step();
    drain();
    ReadEn1 = 1'b0;
    WriteData = 8'h01; ReadReg2 = 2'd3;
    step();
    idle();
    #1;
    check("regrd_hold", 2, 1, 8'h7E);
    check("regrd_hold_stored", 1, 2, 8'h01);

    // Clear beats a same-cycle write; bypass reads 0 during the Clear cycle.
    Clear = 1'b1; Write = 1'b1; WriteReg = 2'd0; WriteData = 8'hFF;
    ReadReg1 = 2'd3; ReadReg2 = 2'd1; ReadEn1 = 1'b1; ReadEn2 = 1'b1;
    #1;
    check("clear_bypass_a", 0, 1, 8'h00);
    check("clear_bypass_b", 0, 2, 8'h00);
    check("clear_nobypass_old", 1, 1, 8'h01);
    push("clear_reg_a", 2, 1, 8'h00);
    push("clear_reg_b", 2, 2, 8'h00);
    step();
    drain();
    idle();
    for (int a = 0; a < 4; a++) begin
      ReadReg1 = 2'(a);
      #1;
      check("clear_stored", 1, 1, 8'h00);
    end

    // Hardwired zero entry: port A to entry 0, port B to entry 1.
    Write = 1'b1; WriteReg = 2'd0; WriteData = 8'h9A;
    Write2 = 1'b1; WriteReg2 = 2'd1; WriteData2 = 8'h9A;
    ReadReg1 = 2'd0; ReadReg2 = 2'd0; ReadEn1 = 1'b1; ReadEn2 = 1'b1;
    #1;
    check("zero_bypass_p1", 3, 1, 8'h00);
    check("zero_bypass_p2", 3, 2, 8'h00);
    check("nozero_bypass", 0, 1, 8'h9A);
    push("zero_reg_p1", 5, 1, 8'h00);
    push("zero_reg_p2", 5, 2, 8'h00);
    push("nozero_reg", 2, 1, 8'h9A);
    step();
    drain();
    idle();
    #1;
    check("zero_nobypass_p1", 4, 1, 8'h00);
    check("zero_nobypass_p2", 4, 2, 8'h00);
    check("nozero_stored", 1, 1, 8'h9A);

    // Hardwired zero entry: port B to entry 0; entry 1 still holds 0x9A.
    Write2 = 1'b1; WriteReg2 = 2'd0; WriteData2 = 8'h9A;
    ReadReg1 = 2'd0; ReadReg2 = 2'd1; ReadEn1 = 1'b1; ReadEn2 = 1'b1;
    #1;
    check("zero_b_bypass_p1", 3, 1, 8'h00);
    check("zero_b_bypass_p2", 3, 2, 8'h9A);
    push("zero_b_reg_p1", 5, 1, 8'h00);
    push("zero_b_reg_p2", 5, 2, 8'h9A);
    step();
    drain();
    idle();
    #1;
    check("zero_b_nobypass_p1", 4, 1, 8'h00);
    check("zero_b_nobypass_p2", 4, 2, 8'h9A);
    check("zero_b_nozero", 1, 1, 8'h9A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the datapath: 2^ADDR_W entries of DATA_W bits, two read ports and two write ports. Writes commit on the rising clock edge. Reads are either combinational with write-bypass or registered with one cycle of latency, selected by parameter. It replaces the fixed 4x8 single-write register file. It adds a clocked write path, an asynchronous reset, a synchronous clear, an optional hardwired-zero register 0 and deterministic same-cycle hazard behaviour.

## Interface
- DATA_W, 8, data width in bits (>=1)
- ADDR_W, 2, address width; depth = 2^ADDR_W (>=1)
- READ_LAT, 0, 0 = combinational read; 1 = registered read, 1-cycle latency
- BYPASS, 1, READ_LAT=0 only; 1 = same-cycle write data forwarded to read outputs
- ZERO_REG, 0, 1 = entry 0 reads 0 and ignores writes
- clk  in  1  clock, rising edge active
- reset  in  1  asynchronous, active-low; clears all entries and output registers
- Clear  in  1  synchronous clear of all entries
- Write  in  1  write enable, port A
- WriteReg  in  ADDR_W  write address, port A
- WriteData  in  DATA_W  write data, port A
- Write2  in  1  write enable, port B
- WriteReg2  in  ADDR_W  write address, port B
- WriteData2  in  DATA_W  write data, port B
- ReadReg1, ReadReg2  in  ADDR_W  read addresses
- ReadEn1, ReadEn2  in  1  read-register load enables (READ_LAT=1 only; ignored when 0)
- ReadData1, ReadData2  out  DATA_W  read data

## Operation
- Reset: reset low clears every entry to 0 immediately, independent of clk. In READ_LAT=1 it also clears the ReadData registers. While reset is low, all writes, Clear and read loads are ignored.
- Write commit at a rising edge, with priority from highest to lowest:
  - Clear=1: every entry becomes 0, and both write ports are ignored that cycle.
  - Write2=1: entry[WriteReg2] takes WriteData2.
  - Write=1: entry[WriteReg] takes WriteData.
  - If both ports target the same address, port B wins. If they target different addresses, both commit.
- ZERO_REG=1: writes to entry 0 are dropped, and any read of entry 0 returns 0 in every mode, including under bypass.
- "Next value" of address a = the value entry[a] will hold after the current edge under the rules above: 0 if Clear; else WriteData2 if B hits a; else WriteData if A hits a; else the current contents. ZERO_REG forces next value 0 for a=0.
- READ_LAT=0, BYPASS=1: ReadDataN = next value of ReadRegN. This is combinational, i.e. write-first forwarding.
- READ_LAT=0, BYPASS=0: ReadDataN = current stored entry[ReadRegN]. Writes become visible the cycle after commit.
- READ_LAT=1: at a rising edge with ReadEnN=1, the ReadDataN register loads the next value of ReadRegN, so write-first holds across the edge. With ReadEnN=0 the register holds its value.
- Both read ports may address the same entry. Each read port is independent of the other.
- There are no error conditions; every address is in range by construction.

## Timing
- Write-to-storage: visible in the array one cycle after the edge.
- READ_LAT=0:
  - BYPASS=1: zero-cycle read-after-write within the same cycle.
  - BYPASS=0: one-cycle read-after-write.
- READ_LAT=1: data appears on ReadDataN in the cycle after the ReadEnN edge. A write and a read to the same address in the same cycle return the new data.
- Reset asserted mid-operation: the array and output registers clear asynchronously. On deassertion, the first edge with reset high behaves normally. Reset deassertion is synchronised externally.
- Reset values: every entry = 0, ReadData1 = ReadData2 = 0. In READ_LAT=0 these are 0 because the array is 0.
- Clear: takes one cycle and is not a multi-cycle sequence. In READ_LAT=0/BYPASS=1, reads return 0 during the Clear cycle.

## Test plan
- Reset: DATA_W=8, ADDR_W=2. Write 0xA5 to all four entries, pulse reset low between clock edges. Expect ReadData1/2 = 0x00 immediately for every address, with no clock edge required.
- Dual-write conflict: Write=1 WriteReg=2 WriteData=0x11 together with Write2=1 WriteReg2=2 WriteData2=0x22. Next cycle, read address 2: expect 0x22. A/B to addresses 1/3 with 0x33/0x44: expect both stored.
- Bypass, READ_LAT=0 BYPASS=1: Write WriteReg=1 WriteData=0x5C with ReadReg1=1 in the same cycle. Expect ReadData1=0x5C before the edge. Repeat with BYPASS=0: expect the old value, then 0x5C after the edge.
- Registered read, READ_LAT=1:
  - Write entry 3 = 0x7E and ReadEn1=1, ReadReg1=3 in the same cycle: expect ReadData1=0x7E one cycle later.
  - Drop ReadEn1 and write 0x01 to entry 3: ReadData1 holds 0x7E.
- Clear priority: Clear=1 together with Write WriteReg=0 WriteData=0xFF. Afterwards all entries read 0x00. With BYPASS=1, expect reads of 0 in the Clear cycle.
- ZERO_REG=1: write 0x9A to entry 0 via port A and port B. Reads of address 0 return 0x00 on both ports in all three read modes. Entry 1 written with 0x9A reads 0x9A.
